sb_trans_scheduler: RTL and testbench



---
 rtl/sb_trans_scheduler_if.sv | 31 +++
 rtl/sb_trans_scheduler.sv | 175 +++++++++++++++++
 tb/tb_sb_trans_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_trans_scheduler_if.sv
// Request, generator-handshake and status signals between the sideband
// transaction scheduler and its requesters / transaction generator.
interface sb_trans_scheduler_if #(
    parameter int unsigned MAX_RETRY = 2
);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic          disconnected_s;
    logic          trans_sent;
    logic          lt_req;
    logic          at_cmd_req;
    logic          at_rsp_req;
    logic          at_rsp_rcvd;
    logic [2:0]    trans_sel;
    logic          busy;
    logic          lt_done;
    logic          at_rsp_done;
    logic          at_cmd_done;
    logic          at_cmd_fail;
    logic [RW-1:0] retry_cnt;

    modport master (
        output disconnected_s, trans_sent, lt_req, at_cmd_req, at_rsp_req, at_rsp_rcvd,
        input  trans_sel, busy, lt_done, at_rsp_done, at_cmd_done, at_cmd_fail, retry_cnt
    );

    modport slave (
        input  disconnected_s, trans_sent, lt_req, at_cmd_req, at_rsp_req, at_rsp_rcvd,
        output trans_sel, busy, lt_done, at_rsp_done, at_cmd_done, at_cmd_fail, retry_cnt
    );
endinterface

// File: rtl/sb_trans_scheduler.sv
// Arbitrates LSE/CLSE, AT command and AT response requests onto the sideband
// generator one at a time, with inter-transaction gap and AT response timeout/retry.
module sb_trans_scheduler #(
    parameter int unsigned AT_TIMEOUT = 1000,
    parameter int unsigned MAX_RETRY  = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 sb_clk,
    input  logic                 rst,
    sb_trans_scheduler_if.slave  bus
);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = (AT_TIMEOUT > 1) ? $clog2(AT_TIMEOUT) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(AT_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_CMD  = 3'd2;
    localparam logic [2:0] CODE_RSP  = 3'd3;
    localparam logic [2:0] CODE_LT   = 3'd4;

    typedef enum logic [2:0] {
        S_DISC,
        S_IDLE,
        S_ISSUE,
        S_WAIT_SENT,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [2:0]    r_sel;
    logic          r_pend_lt;
    logic          r_pend_rsp;
    logic          r_pend_cmd;
    logic          r_outstanding;
    logic [TW-1:0] r_tmo_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [RW-1:0] r_retry;
    logic [2:0]    r_trans_sel;
    logic          r_busy;
    logic          r_lt_done;
    logic          r_rsp_done;
    logic          r_cmd_done;
    logic          r_cmd_fail;

    logic [2:0]    w_pick;
    logic          w_cmd_sent;
    logic          w_cmd_accept;
    logic          w_timeout;
    logic          w_retry;

    always_comb begin
        w_pick = CODE_NONE;
        if (r_pend_rsp)      w_pick = CODE_RSP;
        else if (r_pend_lt)  w_pick = CODE_LT;
        else if (r_pend_cmd) w_pick = CODE_CMD;
    end

    assign w_cmd_sent   = (r_state == S_WAIT_SENT) && bus.trans_sent && (r_sel == CODE_CMD);
    assign w_cmd_accept = bus.at_cmd_req && !r_pend_cmd && !r_outstanding;
    assign w_timeout    = r_outstanding && !bus.at_rsp_rcvd && (r_tmo_cnt == TMO_LAST);
    assign w_retry      = w_timeout && (r_retry < RETRY_MAX);

    always_ff @(posedge sb_clk) begin
        // Disconnect acts as a soft reset: no pulses, everything cleared.
        if (rst || ((r_state != S_DISC) && bus.disconnected_s)) begin
            r_state       <= S_DISC;
            r_sel         <= CODE_NONE;
            r_pend_lt     <= 1'b0;
            r_pend_rsp    <= 1'b0;
            r_pend_cmd    <= 1'b0;
            r_outstanding <= 1'b0;
            r_tmo_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_retry       <= '0;
            r_trans_sel   <= CODE_NONE;
            r_busy        <= 1'b0;
            r_lt_done     <= 1'b0;
            r_rsp_done    <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_cmd_fail    <= 1'b0;
        end else begin
            r_trans_sel <= CODE_NONE;
            r_lt_done   <= 1'b0;
            r_rsp_done  <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_cmd_fail  <= 1'b0;

            if (r_outstanding) begin
                if (bus.at_rsp_rcvd) begin
                    r_outstanding <= 1'b0;
                    r_cmd_done    <= 1'b1;
                    r_retry       <= '0;
                end else if (w_timeout) begin
                    r_outstanding <= 1'b0;
                    if (w_retry) begin
                        r_retry <= r_retry + 1'b1;
                    end else begin
                        r_cmd_fail <= 1'b1;
                        r_retry    <= '0;
                    end
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
            if (w_cmd_sent) begin
                r_outstanding <= 1'b1;
                r_tmo_cnt     <= '0;
            end

            case (r_state)
                S_DISC: begin
                    if (!bus.disconnected_s) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_pick != CODE_NONE) begin
                        r_sel       <= w_pick;
                        r_trans_sel <= w_pick;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                        if (w_pick == CODE_RSP) r_pend_rsp <= 1'b0;
                        if (w_pick == CODE_LT)  r_pend_lt  <= 1'b0;
                        if (w_pick == CODE_CMD) r_pend_cmd <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_SENT;
                end
                S_WAIT_SENT: begin
                    if (bus.trans_sent) begin
                        r_lt_done  <= (r_sel == CODE_LT);
                        r_rsp_done <= (r_sel == CODE_RSP);
                        r_gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_DISC;
            endcase

            // Request sets follow the IDLE clear so a same-cycle repeat is queued.
            if (r_state != S_DISC) begin
                if (bus.lt_req)              r_pend_lt  <= 1'b1;
                if (bus.at_rsp_req)          r_pend_rsp <= 1'b1;
                if (w_cmd_accept || w_retry) r_pend_cmd <= 1'b1;
            end else if (w_retry) begin
                r_pend_cmd <= 1'b1;
            end
        end
    end

    assign bus.trans_sel   = r_trans_sel;
    assign bus.busy        = r_busy;
    assign bus.lt_done     = r_lt_done;
    assign bus.at_rsp_done = r_rsp_done;
    assign bus.at_cmd_done = r_cmd_done;
    assign bus.at_cmd_fail = r_cmd_fail;
    assign bus.retry_cnt   = r_retry;

endmodule

// File: tb/tb_sb_trans_scheduler.sv
// Bench for sb_trans_scheduler: directed scenarios plus a random phase, all
// checked every cycle against an event/deadline-level reference model.
module tb_sb_trans_scheduler;
    localparam int unsigned AT_TIMEOUT = 1000;
    localparam int unsigned MAX_RETRY  = 2;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned C_CMD = 2;
    localparam int unsigned C_RSP = 3;
    localparam int unsigned C_LT  = 4;

    logic sb_clk = 1'b0;
    logic rst;

    sb_trans_scheduler_if #(.MAX_RETRY(MAX_RETRY)) bus ();

    sb_trans_scheduler #(
        .AT_TIMEOUT(AT_TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .sb_clk(sb_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 sb_clk = ~sb_clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    // Reference model: pending set per code, in-flight code, ready/deadline edges
    int unsigned prio [3] = '{C_RSP, C_LT, C_CMD};
    bit          m_pend [2:4];
    bit          m_conn, m_out;
    int unsigned m_inflight, m_issue_edge, m_idle_edge, m_deadline, m_retry;
    int unsigned e_sel;
    bit          e_busy, e_lt_done, e_rsp_done, e_cmd_done, e_fail;

    bit          rand_mode;
    bit          prev_busy;
    int unsigned gen_delay, gen_sent_edge, last_sent_edge;
    int unsigned seen [$];
    int unsigned seen_edge [$];
    int unsigned seen_retry [$];
    int unsigned lt_done_edge, done_edge, fail_edge, busy_fall_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_conn = 1'b0; m_out = 1'b0; m_inflight = 0; m_retry = 0;
        m_issue_edge = 0; m_idle_edge = 0; m_deadline = 0;
    endtask

    task automatic model_edge(input int unsigned e);
        bit old_cmd, old_out, retry_req;
        e_sel = 0; e_busy = 0; e_lt_done = 0; e_rsp_done = 0; e_cmd_done = 0; e_fail = 0;
        if (rst || (m_conn && bus.disconnected_s)) begin
            model_clear();
            return;
        end
        if (!m_conn) begin
            if (!bus.disconnected_s) begin
                m_conn = 1'b1;
                m_idle_edge = e;
            end
            return;
        end
        old_cmd = m_pend[C_CMD]; old_out = m_out; retry_req = 1'b0;
        if (m_out && bus.at_rsp_rcvd) begin
            e_cmd_done = 1'b1; m_out = 1'b0; m_retry = 0;
        end else if (m_out && e == m_deadline) begin
            m_out = 1'b0;
            if (m_retry < MAX_RETRY) begin
                m_retry++; retry_req = 1'b1;
            end else begin
                e_fail = 1'b1; m_retry = 0;
            end
        end
        if (m_inflight != 0 && bus.trans_sent && e >= m_issue_edge + 2) begin
            e_lt_done  = (m_inflight == C_LT);
            e_rsp_done = (m_inflight == C_RSP);
            if (m_inflight == C_CMD) begin
                m_out = 1'b1; m_deadline = e + AT_TIMEOUT;
            end
            m_inflight  = 0;
            m_idle_edge = e + GAP_CYCLES;
        end else if (m_inflight == 0 && e > m_idle_edge) begin
            foreach (prio[i]) begin
                if (e_sel == 0 && m_pend[prio[i]]) begin
                    e_sel = prio[i];
                    m_pend[prio[i]] = 1'b0;
                end
            end
            if (e_sel != 0) begin
                m_inflight = e_sel; m_issue_edge = e;
            end
        end
        if (retry_req) m_pend[C_CMD] = 1'b1;
        if (bus.lt_req) m_pend[C_LT] = 1'b1;
        if (bus.at_rsp_req) m_pend[C_RSP] = 1'b1;
        if (bus.at_cmd_req && !old_cmd && !old_out) m_pend[C_CMD] = 1'b1;
        e_busy = (m_inflight != 0) || (e < m_idle_edge);
    endtask

    task automatic tick();
        @(posedge sb_clk);
        cyc++;
        model_edge(cyc);
        #1;
        chk("trans_sel",   32'(bus.trans_sel),   32'(e_sel));
        chk("busy",        32'(bus.busy),        32'(e_busy));
        chk("lt_done",     32'(bus.lt_done),     32'(e_lt_done));
        chk("at_rsp_done", 32'(bus.at_rsp_done), 32'(e_rsp_done));
        chk("at_cmd_done", 32'(bus.at_cmd_done), 32'(e_cmd_done));
        chk("at_cmd_fail", 32'(bus.at_cmd_fail), 32'(e_fail));
        chk("retry_cnt",   32'(bus.retry_cnt),   m_retry);
        if (bus.trans_sel != 3'd0) begin
            seen.push_back(32'(bus.trans_sel));
            seen_edge.push_back(cyc);
            seen_retry.push_back(32'(bus.retry_cnt));
        end
        if (bus.lt_done)     lt_done_edge = cyc;
        if (bus.at_cmd_done) done_edge = cyc;
        if (bus.at_cmd_fail) fail_edge = cyc;
        if (prev_busy && !bus.busy) busy_fall_edge = cyc;
        prev_busy = bus.busy;
        if (e_sel != 0) gen_sent_edge = cyc + 2 + (rand_mode ? $urandom_range(0, 3) : gen_delay);
        bus.lt_req = 1'b0; bus.at_cmd_req = 1'b0; bus.at_rsp_req = 1'b0;
        bus.at_rsp_rcvd = 1'b0; bus.trans_sent = 1'b0;
        if (m_inflight != 0 && gen_sent_edge == cyc + 1) begin
            bus.trans_sent = 1'b1;
            last_sent_edge = cyc + 1;
        end
        if (rand_mode) begin
            bus.lt_req      = ($urandom_range(0, 15) == 0);
            bus.at_rsp_req  = ($urandom_range(0, 15) == 0);
            bus.at_cmd_req  = ($urandom_range(0, 39) == 0);
            bus.at_rsp_rcvd = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0) bus.trans_sent = 1'b1;
            if (bus.disconnected_s) bus.disconnected_s = ($urandom_range(0, 3) != 0);
            else                    bus.disconnected_s = ($urandom_range(0, 799) == 0);
        end
    endtask

    task automatic wait_quiet(input string tag, input int unsigned bound);
        int unsigned n = 0;
        while (!(m_inflight == 0 && !m_pend[C_LT] && !m_pend[C_RSP] && !m_pend[C_CMD]
                 && cyc > m_idle_edge) && n < bound) begin
            tick();
            n++;
        end
        n_assert++;
        assert (n < bound) else begin
            n_fail++;
            $error("FAIL %s: scheduler not idle after %0d cycles", tag, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned req_e, cmd_sent, n, nseen;
        int unsigned exp_order [3] = '{C_RSP, C_LT, C_CMD};
        model_clear();
        rand_mode = 1'b0; gen_delay = 2; gen_sent_edge = 0; last_sent_edge = 0;
        prev_busy = 1'b0; lt_done_edge = 0; done_edge = 0; fail_edge = 0; busy_fall_edge = 0;
        rst = 1'b1;
        bus.disconnected_s = 1'b1; bus.trans_sent = 1'b0; bus.lt_req = 1'b0;
        bus.at_cmd_req = 1'b0; bus.at_rsp_req = 1'b0; bus.at_rsp_rcvd = 1'b0;

        // Reset, then a request while still disconnected must be dropped
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        bus.lt_req = 1'b1;
        tick();
        bus.disconnected_s = 1'b0;
        tick();

        // Single LSE: issue timing, done pulse and gap
        seen.delete(); seen_edge.delete();
        req_e = cyc + 1;
        bus.lt_req = 1'b1;
        tick();
        wait_quiet("lt_quiet", 50);
        chk("lt_issue_count", seen.size(), 1);
        foreach (seen[i]) begin
            chk("lt_issue_code", seen[i], C_LT);
            chk("lt_issue_edge", seen_edge[i], req_e + 1);
        end
        chk("lt_done_edge", lt_done_edge, last_sent_edge);
        chk("lt_busy_fall", busy_fall_edge, last_sent_edge + GAP_CYCLES);

        // Priority: all three at once -> rsp, lt, cmd
        seen.delete();
        bus.lt_req = 1'b1; bus.at_cmd_req = 1'b1; bus.at_rsp_req = 1'b1;
        tick();
        wait_quiet("prio_quiet", 200);
        chk("prio_count", seen.size(), 3);
        foreach (seen[i]) if (i < 3) chk("prio_order", seen[i], exp_order[i]);

        // AT response 500 cycles after the command's trans_sent
        cmd_sent = last_sent_edge;
        done_edge = 0; fail_edge = 0;
        while (cyc < cmd_sent + 499) tick();
        bus.at_rsp_rcvd = 1'b1;
        tick();
        chk("rsp_done_edge", done_edge, cmd_sent + 500);
        chk("rsp_retry_cnt", 32'(bus.retry_cnt), 0);
        repeat (1100) tick();
        chk("rsp_no_reissue", seen.size(), 3);
        chk("rsp_no_fail", fail_edge, 0);

        // Retry exhaustion
        seen.delete(); seen_retry.delete(); fail_edge = 0;
        bus.at_cmd_req = 1'b1;
        tick();
        n = 0;
        while (fail_edge == 0 && n < 4000) begin
            tick();
            n++;
        end
        n_assert++;
        assert (fail_edge != 0) else begin
            n_fail++;
            $error("FAIL retry_fail_seen: no at_cmd_fail within %0d cycles", n);
        end
        chk("retry_count", seen.size(), 3);
        foreach (seen[i]) begin
            chk("retry_code", seen[i], C_CMD);
            chk("retry_cnt_at_issue", seen_retry[i], i);
        end
        chk("retry_fail_edge", fail_edge, last_sent_edge + AT_TIMEOUT);
        chk("retry_cnt_after_fail", 32'(bus.retry_cnt), 0);

        // Disconnect during WAIT_SENT with a response pending
        seen.delete(); gen_delay = 30;
        bus.lt_req = 1'b1;
        tick();
        repeat (3) tick();
        bus.at_rsp_req = 1'b1;
        tick();
        bus.disconnected_s = 1'b1;
        tick();
        chk("disc_trans_sel", 32'(bus.trans_sel), 0);
        chk("disc_busy", 32'(bus.busy), 0);
        repeat (3) tick();
        bus.disconnected_s = 1'b0;
        tick();
        bus.trans_sent = 1'b1;
        tick();
        repeat (30) tick();
        chk("disc_issue_count", seen.size(), 1);
        nseen = seen.size();

        // Response and timeout on the same edge: response wins
        gen_delay = 1; done_edge = 0; fail_edge = 0;
        bus.at_cmd_req = 1'b1;
        tick();
        wait_quiet("coll_quiet", 50);
        cmd_sent = last_sent_edge;
        while (cyc < cmd_sent + AT_TIMEOUT - 1) tick();
        bus.at_rsp_rcvd = 1'b1;
        tick();
        chk("coll_done_edge", done_edge, cmd_sent + AT_TIMEOUT);
        chk("coll_retry_cnt", 32'(bus.retry_cnt), 0);
        repeat (50) tick();
        chk("coll_no_fail", fail_edge, 0);
        chk("coll_no_reissue", seen.size(), nseen + 1);

        // Random traffic against the model
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        bus.disconnected_s = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
